// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register responder.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic       I2C_RW_WRITE = 1'b0;
  localparam logic       I2C_RW_READ  = 1'b1;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic [6:0] GCALL_ADDR   = 7'h00;

  // Append one received bit to a byte being shifted in MSB first.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
    return {cur[6:0], b};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// SCL/SDA conditioning: 2-FF synchroniser, stability filter, and edge plus
// START/STOP detection on the filtered levels.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic srst,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] raw;
  logic [1:0] filt;
  logic [1:0] prev_reg;

  assign raw = {scl, sda};

  // Index 1 is SCL, index 0 is SDA; both lines idle high.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic       meta_reg;
      logic       sync_reg;
      logic       filt_reg;
      logic [7:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
          filt_reg <= 1'b1;
          cnt_reg  <= 8'd0;
        end else begin
          meta_reg <= raw[gi];
          sync_reg <= meta_reg;
          if (sync_reg == filt_reg) begin
            cnt_reg <= 8'd0;
          end else if (cnt_reg >= 8'(FILT_LEN - 1)) begin
            filt_reg <= sync_reg;
            cnt_reg  <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg <= 2'b11;
    end else begin
      prev_reg <= filt;
    end
  end

  assign sda_level = filt[0];
  assign scl_rise  = filt[1] & ~prev_reg[1];
  assign scl_fall  = ~filt[1] & prev_reg[1];
  // SCL must be high on both samples so an SCL edge is never taken as a bus condition.
  assign start     = filt[1] & prev_reg[1] & prev_reg[0] & ~filt[0];
  assign stop      = filt[1] & prev_reg[1] & ~prev_reg[0] & filt[0];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an auto-incrementing register pointer and a simple register port.
// Define I2C_TGT_GCALL_EN to ACK and discard general-call (8'h00) transfers.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR = 7'h42,
  parameter int         PTR_W    = 8,
  parameter int         FILT_LEN = 3,
  parameter int         SDA_HOLD = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_t,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr,
  output logic             reg_rd,
  input  logic [7:0]       reg_rdata,
  output logic             busy,
  output logic             addr_hit
);

  logic sda_level;
  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;

  i2c_line_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk       (wb_clk_i),
    .srst      (wb_rst_i),
    .scl       (scl_i),
    .sda       (sda_i),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start     (bus_start),
    .stop      (bus_stop)
  );

  i2c_state_t       state_reg;
  logic [3:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             rw_reg;
  logic [7:0]       hold_cnt_reg;
  logic             hold_pend_reg;
  logic             wr_pend_reg;
  logic             rd_cap_reg;
  logic             gcall_reg;
  logic             sda_t_reg;
  logic [PTR_W-1:0] reg_addr_reg;
  logic [7:0]       reg_wdata_reg;
  logic             reg_wr_reg;
  logic             reg_rd_reg;
  logic             busy_reg;
  logic             addr_hit_reg;

  logic [7:0] rx_byte;
  logic       last_bit;
  logic       hold_done;
  logic       sda_t_next;

  assign rx_byte   = shift_in(shift_reg, sda_level);
  assign last_bit  = (bit_cnt_reg == 4'd7);
  assign hold_done = hold_pend_reg && (hold_cnt_reg <= 8'd1);

  // Level to put on SDA once the post-fall hold time has elapsed.
  always_comb begin
    sda_t_next = 1'b1;
    case (state_reg)
      ADDR_ACK, PTR_ACK, WDATA_ACK: sda_t_next = ACK;
      RDATA:                        sda_t_next = shift_reg[7];
      IGNORE:                       sda_t_next = (gcall_reg && bit_cnt_reg == 4'd8) ? ACK : NACK;
      default:                      sda_t_next = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 8'd0;
      rw_reg        <= I2C_RW_WRITE;
      hold_cnt_reg  <= 8'd0;
      hold_pend_reg <= 1'b0;
      wr_pend_reg   <= 1'b0;
      rd_cap_reg    <= 1'b0;
      gcall_reg     <= 1'b0;
      sda_t_reg     <= 1'b1;
      reg_addr_reg  <= '0;
      reg_wdata_reg <= 8'd0;
      reg_wr_reg    <= 1'b0;
      reg_rd_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      addr_hit_reg  <= 1'b0;
    end else begin
      reg_wr_reg   <= wr_pend_reg;
      wr_pend_reg  <= 1'b0;
      reg_rd_reg   <= 1'b0;
      rd_cap_reg   <= reg_rd_reg;
      addr_hit_reg <= 1'b0;
      if (rd_cap_reg) begin
        shift_reg <= reg_rdata;
      end

      if (bus_start) begin
        state_reg     <= ADDR;
        bit_cnt_reg   <= 4'd0;
        sda_t_reg     <= 1'b1;
        hold_pend_reg <= 1'b0;
        gcall_reg     <= 1'b0;
      end else if (bus_stop) begin
        state_reg     <= IDLE;
        sda_t_reg     <= 1'b1;
        busy_reg      <= 1'b0;
        hold_pend_reg <= 1'b0;
        gcall_reg     <= 1'b0;
      end else begin
        if (scl_fall) begin
          hold_pend_reg <= 1'b1;
          hold_cnt_reg  <= 8'(SDA_HOLD);
        end else if (hold_pend_reg) begin
          hold_cnt_reg <= hold_cnt_reg - 8'd1;
          if (hold_done) begin
            hold_pend_reg <= 1'b0;
            sda_t_reg     <= sda_t_next;
          end
        end

        if (scl_rise) begin
          case (state_reg)
            ADDR: begin
              shift_reg   <= rx_byte;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (last_bit) begin
                bit_cnt_reg <= 4'd0;
                if (rx_byte[7:1] == TGT_ADDR) begin
                  addr_hit_reg <= 1'b1;
                  busy_reg     <= 1'b1;
                  rw_reg       <= rx_byte[0];
                  state_reg    <= ADDR_ACK;
                end
`ifdef I2C_TGT_GCALL_EN
                else if (rx_byte == {GCALL_ADDR, I2C_RW_WRITE}) begin
                  // Bit count 8 marks the ACK slot of the byte just received.
                  addr_hit_reg <= 1'b1;
                  busy_reg     <= 1'b1;
                  gcall_reg    <= 1'b1;
                  bit_cnt_reg  <= 4'd8;
                  state_reg    <= IGNORE;
                end
`endif
                else begin
                  state_reg <= IGNORE;
                end
              end
            end
            ADDR_ACK: begin
              bit_cnt_reg <= 4'd0;
              if (rw_reg == I2C_RW_READ) begin
                reg_rd_reg <= 1'b1;
                state_reg  <= RDATA;
              end else begin
                state_reg <= PTR;
              end
            end
            PTR: begin
              shift_reg   <= rx_byte;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (last_bit) begin
                bit_cnt_reg  <= 4'd0;
                reg_addr_reg <= PTR_W'(rx_byte);
                state_reg    <= PTR_ACK;
              end
            end
            PTR_ACK: begin
              state_reg <= WDATA;
            end
            WDATA: begin
              shift_reg   <= rx_byte;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (last_bit) begin
                bit_cnt_reg   <= 4'd0;
                reg_wdata_reg <= rx_byte;
                wr_pend_reg   <= 1'b1;
                state_reg     <= WDATA_ACK;
              end
            end
            WDATA_ACK: begin
              reg_addr_reg <= reg_addr_reg + PTR_W'(1);
              state_reg    <= WDATA;
            end
            RDATA: begin
              shift_reg   <= {shift_reg[6:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (last_bit) begin
                bit_cnt_reg <= 4'd0;
                state_reg   <= RDATA_ACK;
              end
            end
            RDATA_ACK: begin
              // Pointer and read request land together so reg_rd sees the new address.
              if (sda_level == ACK) begin
                reg_addr_reg <= reg_addr_reg + PTR_W'(1);
                reg_rd_reg   <= 1'b1;
                state_reg    <= RDATA;
              end else begin
                state_reg <= IGNORE;
              end
            end
            IGNORE: begin
              if (gcall_reg) begin
                if (bit_cnt_reg == 4'd8) begin
                  bit_cnt_reg <= 4'd0;
                end else if (last_bit) begin
                  bit_cnt_reg <= 4'd8;
                end else begin
                  bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign sda_o     = 1'b0;
  assign sda_t     = sda_t_reg;
  assign reg_addr  = reg_addr_reg;
  assign reg_wdata = reg_wdata_reg;
  assign reg_wr    = reg_wr_reg;
  assign reg_rd    = reg_rd_reg;
  assign busy      = busy_reg;
  assign addr_hit  = addr_hit_reg;

endmodule
